// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares one single-ported memory between the 6502 core (default
//             priority) and a DMA/test-loader requester. DMA is given a
//             guaranteed slot after a bounded wait and may lock a short burst.
//  Revision : 1.0  initial release
// ============================================================================
module mem_arbiter #(
  parameter int STARVE_MAX = 4,  // cycles DMA may be refused before a forced slot (1..15)
  parameter int BURST_MAX  = 4   // longest locked DMA burst in grants (1..15)
) (
  input  logic        ph2,
  input  logic        resetb,
  // core side
  input  logic        core_req,
  input  logic        core_we,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  output logic        core_ready,
  output logic [7:0]  core_rdata,
  // DMA side
  input  logic        dma_req,
  input  logic        dma_lock,
  input  logic        dma_we,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [7:0]  dma_rdata,
  // memory side
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam logic [3:0] C_STARVE_LAST = 4'(STARVE_MAX - 1);
  localparam logic [3:0] C_BURST_MAX   = 4'(BURST_MAX);
  localparam logic       C_CAN_BURST   = (BURST_MAX > 1);

  typedef enum logic [0:0] {
    ST_CORE = 1'b0,
    ST_DMA  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] burst_q, burst_d;
  logic [3:0] burst_inc;
  logic       dma_rvalid_q;
  logic       core_gnt;
  logic       dma_gnt_c;

  // Owner selection; both grants are held off while reset is asserted so the
  // memory sees no strobe even though reset is asynchronous.
  always_comb begin
    core_gnt  = 1'b0;
    dma_gnt_c = 1'b0;
    if (resetb) begin
      if (state_q == ST_CORE) begin
        core_gnt  = core_req;
        dma_gnt_c = !core_req && dma_req;
      end else begin
        dma_gnt_c = dma_req;
        core_gnt  = !dma_req && core_req;
      end
    end
  end

  // Next state and counter update; counters saturate instead of wrapping.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    burst_d   = burst_q;
    burst_inc = (burst_q == 4'hF) ? 4'hF : burst_q + 4'd1;
    case (state_q)
      ST_CORE: begin
        if (dma_gnt_c) begin
          wait_d = 4'd0;
          if (dma_lock && C_CAN_BURST) begin
            state_d = ST_DMA;
            burst_d = 4'd1;
          end
        end else if (!dma_req) begin
          wait_d = 4'd0;
        end else if (core_req) begin
          // Conflict: DMA has been refused; force its slot once the wait is used up.
          if (wait_q >= C_STARVE_LAST) begin
            state_d = ST_DMA;
            wait_d  = 4'd0;
            burst_d = 4'd0;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
      end
      ST_DMA: begin
        // A lock drop coinciding with the burst limit is just one exit.
        if (!dma_req || !dma_lock || (burst_inc >= C_BURST_MAX)) begin
          state_d = ST_CORE;
          wait_d  = 4'd0;
          burst_d = 4'd0;
        end else begin
          burst_d = burst_inc;
        end
      end
      default: begin
        state_d = ST_CORE;
        wait_d  = 4'd0;
        burst_d = 4'd0;
      end
    endcase
  end

  // Arbitration state and the DMA read-valid flag.
  always_ff @(posedge ph2 or negedge resetb) begin
    if (!resetb) begin
      state_q      <= ST_CORE;
      wait_q       <= 4'd0;
      burst_q      <= 4'd0;
      dma_rvalid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      burst_q      <= burst_d;
      dma_rvalid_q <= dma_gnt_c && !dma_we;
    end
  end

  // Memory port mux: the core drives address/data whenever DMA is not granted,
  // but an ungranted requester can never raise the write enable.
  assign mem_en     = core_gnt || dma_gnt_c;
  assign mem_we     = dma_gnt_c ? dma_we : (core_gnt && core_we);
  assign mem_addr   = dma_gnt_c ? dma_addr : core_addr;
  assign mem_wdata  = dma_gnt_c ? dma_wdata : core_wdata;

  assign dma_gnt    = dma_gnt_c;
  assign core_ready = !resetb || !core_req || core_gnt;
  assign core_rdata = mem_rdata;
  assign dma_rdata  = mem_rdata;
  assign dma_rvalid = dma_rvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Directed, table-driven bench for mem_arbiter with a small
//             behavioural memory behind it.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

  logic        ph2 = 1'b0;
  logic        resetb;
  logic        core_req, core_we, dma_req, dma_lock, dma_we;
  logic [15:0] core_addr, dma_addr;
  logic [7:0]  core_wdata, dma_wdata;
  logic        core_ready, dma_gnt, dma_rvalid, mem_en, mem_we;
  logic [7:0]  core_rdata, dma_rdata, mem_wdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  ram [0:1023];

  int n_vec  = 0;
  int n_fail = 0;

  mem_arbiter #(.STARVE_MAX(4), .BURST_MAX(4)) dut (
    .ph2(ph2), .resetb(resetb),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_ready(core_ready), .core_rdata(core_rdata),
    .dma_req(dma_req), .dma_lock(dma_lock), .dma_we(dma_we), .dma_addr(dma_addr),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 ph2 = ~ph2;

  // Synchronous single-port memory, read data one cycle after the strobe.
  always @(posedge ph2) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[9:0]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[9:0]];
    end
  end

  typedef struct {
    logic        creq, cwe;
    logic [15:0] cadr;
    logic [7:0]  cwd;
    logic        dreq, dlk, dwe;
    logic [15:0] dadr;
    logic [7:0]  dwd;
    logic        e_rdy, e_gnt, e_en, e_we;
    logic [15:0] e_addr;
    logic        e_rv, chk_rd;
    logic [7:0]  e_rd;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic creq, logic cwe, logic [15:0] cadr, logic [7:0] cwd,
                              logic dreq, logic dlk, logic dwe, logic [15:0] dadr,
                              logic [7:0] dwd, logic e_rdy, logic e_gnt, logic e_en,
                              logic e_we, logic [15:0] e_addr, logic e_rv,
                              logic chk_rd, logic [7:0] e_rd);
    vec_t v;
    v.creq = creq; v.cwe = cwe; v.cadr = cadr; v.cwd = cwd;
    v.dreq = dreq; v.dlk = dlk; v.dwe = dwe; v.dadr = dadr; v.dwd = dwd;
    v.e_rdy = e_rdy; v.e_gnt = e_gnt; v.e_en = e_en; v.e_we = e_we;
    v.e_addr = e_addr; v.e_rv = e_rv; v.chk_rd = chk_rd; v.e_rd = e_rd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic creq, input logic cwe, input logic [15:0] cadr,
                       input logic [7:0] cwd, input logic dreq, input logic dlk,
                       input logic dwe, input logic [15:0] dadr, input logic [7:0] dwd);
    core_req = creq; core_we = cwe; core_addr = cadr; core_wdata = cwd;
    dma_req = dreq; dma_lock = dlk; dma_we = dwe; dma_addr = dadr; dma_wdata = dwd;
  endtask

  // Conflict until a forced DMA slot; lock is dropped on beat drop_beat
  // (0 = never dropped, so the burst limit ends it).
  task automatic run_burst(input int drop_beat);
    int beats;
    logic exp_gnt;
    beats = (drop_beat == 0) ? 4 : drop_beat;
    for (int i = 0; i < 10; i++) begin
      exp_gnt = (i >= 4) && (i < 4 + beats);
      drive(1'b1, 1'b0, 16'h0300, 8'h00, 1'b1,
            (drop_beat != 0 && i == 4 + drop_beat - 1) ? 1'b0 : 1'b1,
            1'b1, 16'h0100 + 16'(i), 8'(8'hA0 + i));
      @(negedge ph2);
      chk($sformatf("burst%0d_gnt[%0d]", drop_beat, i), {31'd0, dma_gnt}, {31'd0, exp_gnt});
      chk($sformatf("burst%0d_rdy[%0d]", drop_beat, i), {31'd0, core_ready}, {31'd0, !exp_gnt});
      @(posedge ph2); #1;
    end
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(posedge ph2); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

    tbl[0]  = mk(1,1,16'h0040,8'h42, 0,0,0,16'h0000,8'h00, 1,0,1,1,16'h0040,0, 0,8'h00);
    tbl[1]  = mk(1,0,16'h0040,8'h00, 0,0,0,16'h0000,8'h00, 1,0,1,0,16'h0040,0, 0,8'h00);
    tbl[2]  = mk(0,0,16'h0000,8'h00, 1,0,0,16'h0040,8'h00, 1,1,1,0,16'h0040,0, 1,8'h42);
    tbl[3]  = mk(0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,1, 1,8'h42);
    tbl[4]  = mk(0,0,16'h0000,8'h00, 1,0,1,16'h0080,8'h5A, 1,1,1,1,16'h0080,0, 0,8'h00);
    for (int i = 5; i <= 8; i++)
      tbl[i] = mk(1,1,16'h00A0,8'h77, 1,0,1,16'h0090,8'h11, 1,0,1,1,16'h00A0,0, 0,8'h00);
    tbl[9]  = mk(1,1,16'h00A0,8'h77, 1,0,1,16'h0090,8'h11, 0,1,1,1,16'h0090,0, 0,8'h00);
    tbl[10] = mk(1,1,16'h00A0,8'h77, 1,0,1,16'h0090,8'h11, 1,0,1,1,16'h00A0,0, 0,8'h00);
    tbl[11] = mk(0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,0, 0,8'h00);
    tbl[12] = mk(1,0,16'h0090,8'h00, 0,0,0,16'h0000,8'h00, 1,0,1,0,16'h0090,0, 0,8'h00);
    tbl[13] = mk(1,0,16'h00A0,8'h00, 0,0,0,16'h0000,8'h00, 1,0,1,0,16'h00A0,0, 1,8'h11);
    tbl[14] = mk(0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,0, 1,8'h77);
    tbl[15] = mk(0,0,16'h0000,8'h00, 1,1,0,16'h0040,8'h00, 1,1,1,0,16'h0040,0, 0,8'h00);
    tbl[16] = mk(1,0,16'h0080,8'h00, 0,0,0,16'h0000,8'h00, 1,0,1,0,16'h0080,1, 1,8'h42);
    tbl[17] = mk(0,0,16'h0000,8'h00, 0,0,0,16'h0000,8'h00, 1,0,0,0,16'h0000,0, 1,8'h5A);

    // Reset held with both requesters asking.
    resetb = 1'b0;
    drive(1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 1'b1, 16'h0000, 8'h00);
    #98;
    chk("rst_mem_en",     {31'd0, mem_en},     32'd0);
    chk("rst_mem_we",     {31'd0, mem_we},     32'd0);
    chk("rst_dma_gnt",    {31'd0, dma_gnt},    32'd0);
    chk("rst_core_ready", {31'd0, core_ready}, 32'd1);
    chk("rst_dma_rvalid", {31'd0, dma_rvalid}, 32'd0);
    #2 resetb = 1'b1;
    #3;
    chk("rel_core_ready", {31'd0, core_ready}, 32'd1);
    chk("rel_dma_gnt",    {31'd0, dma_gnt},    32'd0);
    chk("rel_mem_en",     {31'd0, mem_en},     32'd1);
    @(posedge ph2); #1;

    // Table of single-cycle vectors.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].creq, tbl[i].cwe, tbl[i].cadr, tbl[i].cwd,
            tbl[i].dreq, tbl[i].dlk, tbl[i].dwe, tbl[i].dadr, tbl[i].dwd);
      @(negedge ph2);
      chk($sformatf("v%0d_core_ready", i), {31'd0, core_ready}, {31'd0, tbl[i].e_rdy});
      chk($sformatf("v%0d_dma_gnt", i),    {31'd0, dma_gnt},    {31'd0, tbl[i].e_gnt});
      chk($sformatf("v%0d_mem_en", i),     {31'd0, mem_en},     {31'd0, tbl[i].e_en});
      chk($sformatf("v%0d_mem_we", i),     {31'd0, mem_we},     {31'd0, tbl[i].e_we});
      chk($sformatf("v%0d_mem_addr", i),   {16'd0, mem_addr},   {16'd0, tbl[i].e_addr});
      chk($sformatf("v%0d_dma_rvalid", i), {31'd0, dma_rvalid}, {31'd0, tbl[i].e_rv});
      if (tbl[i].e_we)
        chk($sformatf("v%0d_mem_wdata", i), {24'd0, mem_wdata},
            {24'd0, tbl[i].e_gnt ? tbl[i].dwd : tbl[i].cwd});
      if (tbl[i].chk_rd) begin
        chk($sformatf("v%0d_core_rdata", i), {24'd0, core_rdata}, {24'd0, tbl[i].e_rd});
        chk($sformatf("v%0d_dma_rdata", i),  {24'd0, dma_rdata},  {24'd0, tbl[i].e_rd});
      end
      @(posedge ph2); #1;
    end

    // Locked bursts behind a forced slot: early drop, drop at limit, limit only.
    run_burst(2);
    run_burst(4);
    run_burst(0);
    chk("burst_ram_0104", {24'd0, ram[10'h104]}, {24'd0, 8'hA4});
    chk("burst_ram_0107", {24'd0, ram[10'h107]}, {24'd0, 8'hA7});

    // Reset during the second beat of a locked DMA burst.
    drive(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0200, 8'hDD);
    @(negedge ph2);
    chk("mb_beat1_gnt", {31'd0, dma_gnt}, 32'd1);
    @(posedge ph2); #1;
    drive(1'b1, 1'b0, 16'h0300, 8'h00, 1'b1, 1'b1, 1'b1, 16'h0201, 8'hEE);
    @(negedge ph2);
    chk("mb_beat2_gnt", {31'd0, dma_gnt},    32'd1);
    chk("mb_beat2_rdy", {31'd0, core_ready}, 32'd0);
    #1 resetb = 1'b0;
    #1;
    chk("mb_rst_mem_en",  {31'd0, mem_en},     32'd0);
    chk("mb_rst_dma_gnt", {31'd0, dma_gnt},    32'd0);
    chk("mb_rst_mem_we",  {31'd0, mem_we},     32'd0);
    chk("mb_rst_rdy",     {31'd0, core_ready}, 32'd1);
    @(posedge ph2); #1;
    chk("mb_ram_0200", {24'd0, ram[10'h200]}, {24'd0, 8'hDD});
    chk("mb_ram_0201", {24'd0, ram[10'h201]}, 32'd0);
    resetb = 1'b1;
    @(negedge ph2);
    chk("mb_rel_rdy",     {31'd0, core_ready}, 32'd1);
    chk("mb_rel_dma_gnt", {31'd0, dma_gnt},    32'd0);
    chk("mb_rel_mem_en",  {31'd0, mem_en},     32'd1);
    chk("mb_rel_addr",    {16'd0, mem_addr},   {16'd0, 16'h0300});
    chk("mb_rel_rvalid",  {31'd0, dma_rvalid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single-ported system memory (ROM/RAM block inside `top`) between the 6502 core and a DMA/test-loader requester. The core has default priority; the DMA requester gets a guaranteed slot after a bounded wait and may hold the bus for a locked burst. Sits between `chip.core` and `mem` in `top`, clocked on `ph2`.

## Interface
- `STARVE_MAX`, 4: consecutive cycles DMA may be denied by the core before it is forced a grant (legal range 1..15).
- `BURST_MAX`, 4: maximum consecutive locked DMA grants (legal range 1..15).

- `ph2`  in  1  single clock, all state updates on rising edge.
- `resetb`  in  1  asynchronous, active-low reset.
- `core_req`  in  1  core access request.
- `core_we`  in  1  core write enable.
- `core_addr`  in  16  core address.
- `core_wdata`  in  8  core write data.
- `core_ready`  out  1  core access accepted this cycle; low = core stalls.
- `core_rdata`  out  8  read data, valid the cycle after an accepted core read.
- `dma_req`  in  1  DMA access request.
- `dma_lock`  in  1  DMA requests burst continuation.
- `dma_we`  in  1  DMA write enable.
- `dma_addr`  in  16  DMA address.
- `dma_wdata`  in  8  DMA write data.
- `dma_gnt`  out  1  DMA access issued this cycle.
- `dma_rvalid`  out  1  `dma_rdata` valid (one cycle after a DMA read grant).
- `dma_rdata`  out  8  DMA read data.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  16  memory address.
- `mem_wdata`  out  8  memory write data.
- `mem_rdata`  in  8  memory read data, one cycle after `mem_en` read.

## Operation
- One memory access issued per cycle; owner selection is combinational from state, counters and requests; state/counters registered.
- States: CORE (default), DMA.
- CORE: grant core if `core_req`; else grant DMA if `dma_req`; else idle (`mem_en`=0).
  - `wait_cnt` increments each cycle `core_req && dma_req`; clears when DMA is granted or `dma_req` low.
  - When `wait_cnt == STARVE_MAX-1` and conflict persists: next cycle enter DMA.
  - DMA granted from CORE with `dma_lock`=1 and `BURST_MAX`>1: enter DMA, `burst_cnt`=1.
- DMA: grant DMA if `dma_req`; `core_ready`=0 if `core_req`. `burst_cnt` increments per grant.
  - Exit to CORE (counters cleared) when `dma_req`=0, `dma_lock`=0 on a grant, or `burst_cnt` reaches `BURST_MAX`.
  - `dma_req`=0 in DMA: no DMA grant; core granted same cycle if `core_req`.
- Mux: `mem_addr/mem_we/mem_wdata` from granted requester; from core when idle, with `mem_we`=0.
- `core_ready` = !`core_req` || core granted.
- `core_rdata` = `dma_rdata` = `mem_rdata` (pass-through).
- `dma_rvalid` = registered (DMA granted && !`dma_we`).
- Writes by ungranted requester never reach memory.

## Timing
- Reset (`resetb`=0, async): state CORE, `wait_cnt`=`burst_cnt`=0, `dma_rvalid`=0; `mem_en`, `mem_we`, `dma_gnt` forced 0; `core_ready`=1; `mem_addr`/`mem_wdata` follow core inputs.
- Reset mid-burst: burst abandoned immediately; after release, arbitration restarts in CORE.
- Grant latency: uncontended 0 cycles; contended DMA worst case `STARVE_MAX` cycles.
- Read latency: 1 cycle for both requesters.
- Simultaneous `dma_lock` drop and `burst_cnt` limit: single exit to CORE, no extra cycle.
- Forced DMA slot with `dma_lock`=0: exactly one DMA access, then CORE.
- Counters saturate; never wrap.

## Test plan
- Reset held 100 ns with both requests high -> `mem_en`=0, `dma_gnt`=0, `core_ready`=1; first core grant on first edge after release.
- Core write 0x42 to 0x0040, no DMA -> `core_ready`=1, RAM[64]=0x42 next edge; core read returns 0x42 one cycle later.
- Core idle, DMA read 0x0040 -> `dma_gnt`=1 same cycle, `dma_rvalid`=1 with `dma_rdata`=0x42 next cycle.
- Both requesting continuously, `dma_lock`=0, defaults -> pattern 4 core grants, 1 DMA grant (`core_ready`=0 that cycle), repeating.
- Locked DMA burst with core requesting, `BURST_MAX`=4 -> exactly 4 consecutive `dma_gnt`, `core_ready`=0 for those 4 cycles, then core granted.
- Assert `resetb` low during 2nd burst beat -> `mem_en`/`dma_gnt` drop asynchronously; no further DMA writes; state CORE after release.
